lsu_mem_initiator: RTL

//  Load/store initiator between the execute stage and the byte-enabled data memory.
//  - Accepts one load/store request at a time from the pipeline.
//  - Issues a word-aligned access with per-byte write enables to the memory.
//  - Waits the memory read latency, extracts and sign/zero-extends load data.
//  - Returns a response, or an error for misaligned or illegal Funct3.

---
 rtl/lsu_mem_initiator_if.sv | 44 ++++
 rtl/lsu_mem_initiator.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/lsu_mem_initiator_if.sv
// Pipeline request/response and data-memory signals of the load/store initiator.
// master = the LSU itself, slave = the pipeline/memory environment around it.
interface lsu_mem_initiator_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [2:0]            req_funct3;
    logic [DM_ADDRESS-1:0] req_addr;
    logic [DATA_W-1:0]     req_wdata;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_W-1:0]     resp_rdata;
    logic                  resp_err;

    logic [DM_ADDRESS-1:0] mem_addr;
    logic                  mem_re;
    logic [3:0]            mem_wr;
    logic [DATA_W-1:0]     mem_wd;
    logic [DATA_W-1:0]     mem_rd;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid may not depend on ready, and the producer holds its payload until that edge.
    modport master (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        input  resp_ready,
        output mem_addr, mem_re, mem_wr, mem_wd,
        input  mem_rd
    );

    modport slave (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        output resp_ready,
        input  mem_addr, mem_re, mem_wr, mem_wd,
        output mem_rd
    );
endinterface

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: takes one request, drives a word-aligned byte-enabled memory
// access, waits the read latency and returns extended load data or an error.
module lsu_mem_initiator #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    lsu_mem_initiator_if.master  bus,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // WAIT is entered one cycle after ISSUE, so the counter starts at latency-1.
    localparam logic [1:0] WAIT_INIT = (RD_LATENCY > 0) ? 2'(RD_LATENCY - 1) : 2'd0;

    state_t     state;
    logic       op_write;
    logic [2:0] op_funct3;
    logic [1:0] op_lane;
    logic [1:0] wait_cnt;

    assign dbg_state = state;

    function automatic logic req_ok(input logic wr, input logic [2:0] f3, input logic [1:0] lane);
        logic legal;
        logic aligned;
        if (wr) legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        else    legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                        (f3 == 3'b100) || (f3 == 3'b101);
        case (f3[1:0])
            2'b01:   aligned = ~lane[0];
            2'b10:   aligned = (lane == 2'b00);
            default: aligned = 1'b1;
        endcase
        return legal && aligned;
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lane);
        case (f3[1:0])
            2'b00:   store_be = 4'b0001 << lane;
            2'b01:   store_be = 4'b0011 << {lane[1], 1'b0};
            default: store_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_wd(input logic [2:0] f3, input logic [31:0] wd);
        case (f3[1:0])
            2'b00:   store_wd = {4{wd[7:0]}};
            2'b01:   store_wd = {2{wd[15:0]}};
            default: store_wd = wd;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] lane,
                                             input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b100:  load_ext = {24'd0, b};
            3'b101:  load_ext = {16'd0, h};
            default: load_ext = word;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            op_write       <= 1'b0;
            op_funct3      <= 3'b000;
            op_lane        <= 2'b00;
            wait_cnt       <= 2'd0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= '0;
            bus.mem_addr   <= '0;
            bus.mem_re     <= 1'b0;
            bus.mem_wr     <= 4'b0000;
            bus.mem_wd     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        op_write      <= bus.req_write;
                        op_funct3     <= bus.req_funct3;
                        op_lane       <= bus.req_addr[1:0];
                        bus.req_ready <= 1'b0;
                        if (req_ok(bus.req_write, bus.req_funct3, bus.req_addr[1:0])) begin
                            state        <= S_ISSUE;
                            bus.mem_addr <= {bus.req_addr[DM_ADDRESS-1:2], 2'b00};
                            bus.mem_re   <= ~bus.req_write;
                            bus.mem_wr   <= bus.req_write ?
                                            store_be(bus.req_funct3, bus.req_addr[1:0]) : 4'b0000;
                            bus.mem_wd   <= store_wd(bus.req_funct3, bus.req_wdata);
                        end else begin
                            // Rejected requests never touch memory.
                            state          <= S_RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                            bus.resp_rdata <= '0;
                        end
                    end
                end
                S_ISSUE: begin
                    bus.mem_re <= 1'b0;
                    bus.mem_wr <= 4'b0000;
                    if (op_write) begin
                        state          <= S_RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b0;
                        bus.resp_rdata <= '0;
                    end else if (RD_LATENCY == 0) begin
                        state          <= S_RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b0;
                        bus.resp_rdata <= load_ext(op_funct3, op_lane, bus.mem_rd);
                    end else begin
                        state    <= S_WAIT;
                        wait_cnt <= WAIT_INIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        state          <= S_RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b0;
                        bus.resp_rdata <= load_ext(op_funct3, op_lane, bus.mem_rd);
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        state          <= S_IDLE;
                        bus.resp_valid <= 1'b0;
                        bus.req_ready  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
